// File: rtl/vu_bar_display.sv
// VGA bar-graph renderer for the multi-channel VU meter: one horizontal bar per channel, levels sampled once per frame.
// Define PEAK_HOLD_EN to add per-channel peak-hold registers and a white peak marker.
module vu_bar_display #(
    parameter int CH_NO            = 4,
    parameter int H_DISPLAY        = 640,
    parameter int H_FP             = 16,
    parameter int H_RETRACE        = 96,
    parameter int H_BP             = 48,
    parameter int V_DISPLAY        = 480,
    parameter int V_FP             = 10,
    parameter int V_RETRACE        = 2,
    parameter int V_BP             = 33,
    parameter int X_OFFSET         = 64,
    parameter int FACTOR           = 2,
    parameter int GAP              = 8,
    parameter int GREEN_LIM        = 400,
    parameter int YELLOW_LIM       = 520,
    parameter int PEAK_HOLD_FRAMES = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CH_NO*8-1:0] data_in,
    output logic [7:0]         data_out,
    output logic               h_sync,
    output logic               v_sync,
    output logic               frame_start
);

    localparam int H_WIDTH  = H_DISPLAY + H_FP + H_RETRACE + H_BP;
    localparam int V_HEIGHT = V_DISPLAY + V_FP + V_RETRACE + V_BP;
    localparam int BAND     = V_DISPLAY / CH_NO;

    localparam logic [10:0] H_LAST    = 11'(H_WIDTH - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_HEIGHT - 1);
    localparam logic [10:0] H_ACT     = 11'(H_DISPLAY);
    localparam logic [9:0]  V_ACT     = 10'(V_DISPLAY);
    localparam logic [10:0] HS_START  = 11'(H_DISPLAY + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_DISPLAY + H_FP + H_RETRACE);
    localparam logic [9:0]  VS_START  = 10'(V_DISPLAY + V_FP);
    localparam logic [9:0]  VS_END    = 10'(V_DISPLAY + V_FP + V_RETRACE);
    localparam logic [9:0]  BAND_LAST = 10'(BAND - 1);
    localparam logic [9:0]  ROW_FIRST = 10'(GAP);
    localparam logic [9:0]  ROW_END   = 10'(BAND - GAP);
    localparam logic [10:0] X_OFF     = 11'(X_OFFSET);
    localparam logic [10:0] FACT      = 11'(FACTOR);
    localparam logic [10:0] G_LIM     = 11'(GREEN_LIM);
    localparam logic [10:0] Y_LIM     = 11'(YELLOW_LIM);

    localparam logic [7:0] BLACK  = 8'h00;
    localparam logic [7:0] GREEN  = 8'h38;
    localparam logic [7:0] YELLOW = 8'h3F;
    localparam logic [7:0] RED    = 8'h07;
    localparam logic [7:0] WHITE  = 8'hFF;

    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic [9:0]  band_row;
    logic [9:0]  band_idx;
    logic        frame_end;

    logic [7:0]  level [CH_NO];
    logic [7:0]  level_sel;
    logic [10:0] bar_end;
    logic        in_bar;
    logic        in_marker;
    logic        bar_rows;
    logic        active;
    logic [7:0]  pixel;

    // Band row/index track v_cnt incrementally so no divider is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            band_row <= '0;
            band_idx <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
                v_cnt    <= '0;
                band_row <= '0;
                band_idx <= '0;
            end else begin
                v_cnt <= v_cnt + 10'd1;
                if (band_row == BAND_LAST) begin
                    band_row <= '0;
                    band_idx <= band_idx + 10'd1;
                end else begin
                    band_row <= band_row + 10'd1;
                end
            end
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH_NO; i++) level[i] <= '0;
        end else if (frame_end) begin
            for (int i = 0; i < CH_NO; i++) level[i] <= data_in[8*i +: 8];
        end
    end

    always_comb begin
        level_sel = '0;
        for (int i = 0; i < CH_NO; i++) begin
            if (band_idx == 10'(i)) level_sel = level[i];
        end
    end

    assign bar_end = X_OFF + 11'(level_sel) * FACT;
    assign in_bar  = (level_sel != 8'd0) && (h_cnt >= X_OFF) && (h_cnt < bar_end);

`ifdef PEAK_HOLD_EN
    localparam int HOLD_W = (PEAK_HOLD_FRAMES < 1) ? 1 : $clog2(PEAK_HOLD_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(PEAK_HOLD_FRAMES);

    logic [7:0]        peak [CH_NO];
    logic [HOLD_W-1:0] hold [CH_NO];
    logic [7:0]        peak_sel;
    logic [10:0]       mark_hi;
    logic [10:0]       mark_lo;

    // Peaks update on the same edge as the level latch, against the incoming level.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH_NO; i++) begin
                peak[i] <= '0;
                hold[i] <= '0;
            end
        end else if (frame_end) begin
            for (int i = 0; i < CH_NO; i++) begin
                if (data_in[8*i +: 8] >= peak[i]) begin
                    peak[i] <= data_in[8*i +: 8];
                    hold[i] <= HOLD_INIT;
                end else if (hold[i] != '0) begin
                    hold[i] <= hold[i] - 1'b1;
                end else if (peak[i] != 8'd0) begin
                    peak[i] <= peak[i] - 8'd1;
                end
            end
        end
    end

    always_comb begin
        peak_sel = '0;
        for (int i = 0; i < CH_NO; i++) begin
            if (band_idx == 10'(i)) peak_sel = peak[i];
        end
    end

    assign mark_hi   = X_OFF + 11'(peak_sel) * FACT;
    assign mark_lo   = mark_hi - FACT;
    assign in_marker = (peak_sel != 8'd0) && (h_cnt >= mark_lo) && (h_cnt < mark_hi);
`else
    assign in_marker = 1'b0;
`endif

    assign active   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign bar_rows = (band_row >= ROW_FIRST) && (band_row < ROW_END);

    always_comb begin
        pixel = BLACK;
        if (active && bar_rows) begin
            if (in_bar) begin
                if (h_cnt < G_LIM)      pixel = GREEN;
                else if (h_cnt < Y_LIM) pixel = YELLOW;
                else                    pixel = RED;
            end
            if (in_marker) pixel = WHITE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out    <= BLACK;
            h_sync      <= 1'b1;
            v_sync      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            data_out    <= pixel;
            h_sync      <= !((h_cnt >= HS_START) && (h_cnt < HS_END));
            v_sync      <= !((v_cnt >= VS_START) && (v_cnt < VS_END));
            frame_start <= (h_cnt == 11'd0) && (v_cnt == 10'd0);
        end
    end

endmodule

// File: tb/tb_vu_bar_display.sv
// Directed bench for vu_bar_display; vertical geometry is shrunk so several frames fit in a short run.
// Horizontal timing and bar geometry keep their VGA defaults so pixel positions match the 640-wide layout.
module tb_vu_bar_display;

    localparam int CH_NO            = 4;
    localparam int H_DISPLAY        = 640;
    localparam int H_FP             = 16;
    localparam int H_RETRACE        = 96;
    localparam int H_BP             = 48;
    localparam int V_DISPLAY        = 12;
    localparam int V_FP             = 0;
    localparam int V_RETRACE        = 1;
    localparam int V_BP             = 0;
    localparam int X_OFFSET         = 64;
    localparam int FACTOR           = 2;
    localparam int GAP              = 1;
    localparam int GREEN_LIM        = 400;
    localparam int YELLOW_LIM       = 520;
    localparam int PEAK_HOLD_FRAMES = 1;

    localparam int H_WIDTH = 800;
    localparam int FRAME   = 800 * 13;

    localparam logic [7:0] BLACK  = 8'h00;
    localparam logic [7:0] GREEN  = 8'h38;
    localparam logic [7:0] YELLOW = 8'h3F;
    localparam logic [7:0] RED    = 8'h07;
    localparam logic [7:0] WHITE  = 8'hFF;

`ifdef PEAK_HOLD_EN
    localparam logic [7:0] EXP_CH2_463 = WHITE;
`else
    localparam logic [7:0] EXP_CH2_463 = YELLOW;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_in = '0;
    logic [7:0]  data_out;
    logic        h_sync;
    logic        v_sync;
    logic        frame_start;

    int checks = 0;
    int fails  = 0;

    logic [7:0] frame_buf [V_DISPLAY][H_DISPLAY];

    vu_bar_display #(
        .CH_NO(CH_NO), .H_DISPLAY(H_DISPLAY), .H_FP(H_FP), .H_RETRACE(H_RETRACE), .H_BP(H_BP),
        .V_DISPLAY(V_DISPLAY), .V_FP(V_FP), .V_RETRACE(V_RETRACE), .V_BP(V_BP),
        .X_OFFSET(X_OFFSET), .FACTOR(FACTOR), .GAP(GAP), .GREEN_LIM(GREEN_LIM),
        .YELLOW_LIM(YELLOW_LIM), .PEAK_HOLD_FRAMES(PEAK_HOLD_FRAMES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .data_out(data_out),
        .h_sync(h_sync),
        .v_sync(v_sync),
        .frame_start(frame_start)
    );

    always #20 clk = ~clk;

    function automatic int count_not(input int row, input int lo, input int hi, input logic [7:0] c);
        int n = 0;
        for (int x = lo; x <= hi; x++) if (frame_buf[row][x] !== c) n++;
        return n;
    endfunction

    task automatic wait_frame_start(input string tag);
        int n = 0;
        while (frame_start !== 1'b1 && n < FRAME + 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (frame_start !== 1'b1) begin
            fails++;
            $display("FAIL %s: no frame_start within %0d cycles, required a pulse", tag, n);
        end
    endtask

    // Called on the negedge that shows pixel (0,0); leaves the bench at the start of vertical blanking.
    task automatic capture_frame(input int chg_row, input logic [31:0] chg_val);
        for (int v = 0; v < V_DISPLAY; v++) begin
            for (int h = 0; h < H_WIDTH; h++) begin
                if (v == chg_row && h == 0) data_in = chg_val;
                if (h < H_DISPLAY) frame_buf[v][h] = data_out;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        int fs1 = -1, fs2 = -1, hs_f1 = -1, hs_f2 = -1, hs_r1 = -1, vs_f = -1, vs_r = -1;
        logic prev_hs = 1'b1, prev_vs = 1'b1;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL rst_data_out: got %h want 00", data_out); end
        checks++; if (h_sync !== 1'b1) begin fails++; $display("FAIL rst_h_sync: got %b want 1", h_sync); end
        checks++; if (v_sync !== 1'b1) begin fails++; $display("FAIL rst_v_sync: got %b want 1", v_sync); end
        checks++; if (frame_start !== 1'b0) begin fails++; $display("FAIL rst_frame_start: got %b want 0", frame_start); end
        rst = 1'b0;
        for (int i = 1; i <= FRAME + 100; i++) begin
            @(negedge clk);
            if (prev_hs && !h_sync) begin
                if (hs_f1 < 0) hs_f1 = i;
                else if (hs_f2 < 0) hs_f2 = i;
            end
            if (!prev_hs && h_sync && hs_r1 < 0) hs_r1 = i;
            if (prev_vs && !v_sync && vs_f < 0) vs_f = i;
            if (!prev_vs && v_sync && vs_r < 0) vs_r = i;
            prev_hs = h_sync;
            prev_vs = v_sync;
            if (frame_start === 1'b1) begin
                if (fs1 < 0) fs1 = i;
                else begin
                    fs2 = i;
                    break;
                end
            end
        end
        checks++; if (fs1 != 1) begin fails++; $display("FAIL first_frame_start: got cycle %0d want 1", fs1); end
        checks++; if (hs_f1 != 657) begin fails++; $display("FAIL first_hsync_fall: got cycle %0d want 657", hs_f1); end
        checks++; if (hs_r1 - hs_f1 != 96) begin fails++; $display("FAIL hsync_width: got %0d want 96", hs_r1 - hs_f1); end
        checks++; if (hs_f2 - hs_f1 != 800) begin fails++; $display("FAIL hsync_period: got %0d want 800", hs_f2 - hs_f1); end
        checks++; if (vs_f != 12 * 800 + 1) begin fails++; $display("FAIL vsync_fall: got cycle %0d want 9601", vs_f); end
        checks++; if (vs_r - vs_f != 800) begin fails++; $display("FAIL vsync_width: got %0d want 800", vs_r - vs_f); end
        checks++; if (fs2 - fs1 != FRAME) begin fails++; $display("FAIL frame_period: got %0d want %0d", fs2 - fs1, FRAME); end
    endtask

    // ch0=100, ch1=50, ch2=200, ch3=255 latched at the end of this frame; ch1/ch2 change mid next frame.
    task automatic test_bar_colours();
        data_in = {8'd255, 8'd200, 8'd50, 8'd100};
        @(negedge clk);
        wait_frame_start("bar_frame");
        capture_frame(1, {8'd255, 8'd0, 8'd150, 8'd100});
        checks++; if (count_not(0, 0, 639, BLACK) != 0) begin fails++; $display("FAIL ch0_top_gap: %0d lit pixels, want 0", count_not(0, 0, 639, BLACK)); end
        checks++; if (count_not(2, 0, 639, BLACK) != 0) begin fails++; $display("FAIL ch0_bottom_gap: %0d lit pixels, want 0", count_not(2, 0, 639, BLACK)); end
        checks++; if (count_not(1, 64, 263, GREEN) != 0) begin fails++; $display("FAIL ch0_green_run: %0d non-green, want 0", count_not(1, 64, 263, GREEN)); end
        checks++; if (frame_buf[1][263] !== GREEN) begin fails++; $display("FAIL ch0_x263: got %h want %h", frame_buf[1][263], GREEN); end
        checks++; if (frame_buf[1][264] !== BLACK) begin fails++; $display("FAIL ch0_x264: got %h want %h", frame_buf[1][264], BLACK); end
        checks++; if (frame_buf[1][63] !== BLACK) begin fails++; $display("FAIL ch0_x63: got %h want %h", frame_buf[1][63], BLACK); end
        checks++; if (count_not(10, 64, 399, GREEN) != 0) begin fails++; $display("FAIL ch3_green_zone: %0d wrong, want 0", count_not(10, 64, 399, GREEN)); end
        checks++; if (count_not(10, 400, 519, YELLOW) != 0) begin fails++; $display("FAIL ch3_yellow_zone: %0d wrong, want 0", count_not(10, 400, 519, YELLOW)); end
        checks++; if (count_not(10, 520, 573, RED) != 0) begin fails++; $display("FAIL ch3_red_zone: %0d wrong, want 0", count_not(10, 520, 573, RED)); end
        checks++; if (frame_buf[10][574] !== BLACK) begin fails++; $display("FAIL ch3_x574: got %h want %h", frame_buf[10][574], BLACK); end
        checks++; if (frame_buf[4][163] !== GREEN) begin fails++; $display("FAIL ch1_cur_x163: got %h want %h", frame_buf[4][163], GREEN); end
        checks++; if (frame_buf[4][164] !== BLACK) begin fails++; $display("FAIL ch1_cur_x164: got %h want %h", frame_buf[4][164], BLACK); end
        checks++; if (frame_buf[7][461] !== YELLOW) begin fails++; $display("FAIL ch2_x461: got %h want %h", frame_buf[7][461], YELLOW); end
        checks++; if (frame_buf[7][463] !== EXP_CH2_463) begin fails++; $display("FAIL ch2_x463: got %h want %h", frame_buf[7][463], EXP_CH2_463); end
        checks++; if (frame_buf[7][464] !== BLACK) begin fails++; $display("FAIL ch2_x464: got %h want %h", frame_buf[7][464], BLACK); end
    endtask

    task automatic test_tear_free();
        wait_frame_start("tear_frame");
        capture_frame(-1, data_in);
        checks++; if (count_not(4, 64, 363, GREEN) != 0) begin fails++; $display("FAIL ch1_next_run: %0d non-green, want 0", count_not(4, 64, 363, GREEN)); end
        checks++; if (frame_buf[4][364] !== BLACK) begin fails++; $display("FAIL ch1_next_x364: got %h want %h", frame_buf[4][364], BLACK); end
        checks++; if (count_not(6, 0, 639, BLACK) != 0) begin fails++; $display("FAIL ch2_top_gap: %0d lit pixels, want 0", count_not(6, 0, 639, BLACK)); end
    endtask

`ifdef PEAK_HOLD_EN
    // Frame just captured holds peak 200 with level 0; then decay to 199, then a new peak of 210.
    task automatic test_peak_hold();
        checks++; if (frame_buf[7][462] !== WHITE || frame_buf[7][463] !== WHITE) begin
            fails++; $display("FAIL peak200_marker: got %h %h want ff ff", frame_buf[7][462], frame_buf[7][463]);
        end
        checks++; if (frame_buf[7][461] !== BLACK) begin fails++; $display("FAIL peak200_x461: got %h want 00", frame_buf[7][461]); end
        wait_frame_start("peak_decay_frame");
        capture_frame(1, {8'd255, 8'd210, 8'd150, 8'd100});
        checks++; if (frame_buf[7][460] !== WHITE || frame_buf[7][461] !== WHITE) begin
            fails++; $display("FAIL peak199_marker: got %h %h want ff ff", frame_buf[7][460], frame_buf[7][461]);
        end
        checks++; if (frame_buf[7][462] !== BLACK) begin fails++; $display("FAIL peak199_x462: got %h want 00", frame_buf[7][462]); end
        wait_frame_start("peak_raise_frame");
        capture_frame(-1, data_in);
        checks++; if (frame_buf[7][482] !== WHITE || frame_buf[7][483] !== WHITE) begin
            fails++; $display("FAIL peak210_marker: got %h %h want ff ff", frame_buf[7][482], frame_buf[7][483]);
        end
        checks++; if (frame_buf[7][481] !== YELLOW) begin fails++; $display("FAIL peak210_x481: got %h want 3f", frame_buf[7][481]); end
        checks++; if (frame_buf[7][484] !== BLACK) begin fails++; $display("FAIL peak210_x484: got %h want 00", frame_buf[7][484]); end
    endtask
`endif

    task automatic test_mid_reset();
        int n;
        @(negedge clk);
        wait_frame_start("pre_reset_frame");
        repeat (6 * H_WIDTH) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (data_out !== 8'h00 || h_sync !== 1'b1 || v_sync !== 1'b1 || frame_start !== 1'b0) begin
            fails++; $display("FAIL midrst_outputs: got %h %b %b %b want 00 1 1 0", data_out, h_sync, v_sync, frame_start);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (frame_start !== 1'b1) begin fails++; $display("FAIL midrst_frame_start: got %b want 1", frame_start); end
        capture_frame(-1, data_in);
        checks++; if (count_not(1, 0, 639, BLACK) + count_not(4, 0, 639, BLACK) +
                        count_not(7, 0, 639, BLACK) + count_not(10, 0, 639, BLACK) != 0) begin
            fails++; $display("FAIL midrst_bars_cleared: lit pixels present, want none");
        end
        n = V_DISPLAY * H_WIDTH;
        while (frame_start !== 1'b1 && n < FRAME + 100) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n != FRAME) begin fails++; $display("FAIL midrst_full_frame: got %0d cycles want %0d", n, FRAME); end
    endtask

    initial begin
        test_reset();
        test_bar_colours();
        test_tear_free();
`ifdef PEAK_HOLD_EN
        test_peak_hold();
`endif
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
